// File: rtl/wbs_spi_pkg.sv
// Shared definitions for the wbs_spi Wishbone SPI master: register map,
// STATUS/CTRL field positions and the transfer state type.
package wbs_spi_pkg;

    localparam logic [7:0] ADR_DATA   = 8'h00;
    localparam logic [7:0] ADR_STATUS = 8'h01;
    localparam logic [7:0] ADR_CTRL   = 8'h02;

    localparam int ST_BUSY     = 0;
    localparam int ST_RX_VALID = 1;
    localparam int ST_OVERRUN  = 2;

    localparam int CTRL_DIV_LSB = 0;
    localparam int CTRL_DIV_MSB = 7;
    localparam int CTRL_CS_EN   = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_e;

    function automatic logic [31:0] status_word(input logic busy,
                                                input logic rx_valid,
                                                input logic overrun);
        logic [31:0] w;
        w              = 32'd0;
        w[ST_BUSY]     = busy;
        w[ST_RX_VALID] = rx_valid;
        w[ST_OVERRUN]  = overrun;
        return w;
    endfunction

endpackage

// File: rtl/spi_master_shift.sv
// SPI mode-0 byte engine: divider, 16-phase counter, shift registers and
// SCK/SDO generation. done pulses combinationally on the final phase edge.
module spi_master_shift
    import wbs_spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic [7:0] div,
    input  logic       sdi,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       sck,
    output logic       sdo
);

    spi_state_e state_r, state_s;
    logic [7:0] div_r, div_s;
    logic [7:0] cnt_r, cnt_s;
    logic [3:0] phase_r, phase_s;
    logic [7:0] tx_r, tx_s;
    logic [7:0] rx_r, rx_s;
    logic       sck_r, sck_s;
    logic       sdo_r, sdo_s;
    logic       done_s;

    // Next-state and datapath update for the transfer engine.
    always_comb begin
        state_s = state_r;
        div_s   = div_r;
        cnt_s   = cnt_r;
        phase_s = phase_r;
        tx_s    = tx_r;
        rx_s    = rx_r;
        sck_s   = sck_r;
        sdo_s   = sdo_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SHIFT;
                    div_s   = div;
                    cnt_s   = 8'd0;
                    phase_s = 4'd0;
                    tx_s    = tx_byte;
                    sdo_s   = tx_byte[7];
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == div_r) begin
                    cnt_s   = 8'd0;
                    phase_s = phase_r + 4'd1;
                    if (phase_r == 4'd15) begin
                        // Last phase ends on a falling edge with no further shift.
                        state_s = IDLE;
                        sck_s   = 1'b0;
                        done_s  = 1'b1;
                    end else if (!sck_r) begin
                        sck_s = 1'b1;
                        rx_s  = {rx_r[6:0], sdi};
                    end else begin
                        sck_s = 1'b0;
                        tx_s  = {tx_r[6:0], 1'b0};
                        sdo_s = tx_r[6];
                    end
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
                sck_s   = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            div_r   <= 8'd0;
            cnt_r   <= 8'd0;
            phase_r <= 4'd0;
            tx_r    <= 8'd0;
            rx_r    <= 8'd0;
            sck_r   <= 1'b0;
            sdo_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            div_r   <= div_s;
            cnt_r   <= cnt_s;
            phase_r <= phase_s;
            tx_r    <= tx_s;
            rx_r    <= rx_s;
            sck_r   <= sck_s;
            sdo_r   <= sdo_s;
        end
    end

    assign busy    = (state_r == SHIFT);
    assign done    = done_s;
    assign rx_byte = rx_r;
    assign sck     = sck_r;
    assign sdo     = sdo_r;

endmodule

// File: rtl/wbs_spi.sv
// Wishbone B4 pipelined slave wrapping an SPI mode-0 master: bus decode,
// DATA/STATUS/CTRL registers and the rx_valid/overrun flags.
module wbs_spi
    import wbs_spi_pkg::*;
#(
    parameter logic [7:0] DIV_DEFAULT = 8'd3
) (
    input  logic        wbs_clk_i,
    input  logic        wbs_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [7:0]  wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_stall_o,
    output logic        wbs_ack_o,
    output logic        spi_sck,
    output logic        spi_csn,
    output logic        spi_sdo,
    input  logic        spi_sdi
);

    logic        stall_s, accept_s;
    logic        data_wr_s, start_s, ctrl_wr_s, data_rd_s, status_rd_s;
    logic        busy_s, done_s;
    logic [7:0]  rx_byte_s;
    logic [31:0] rd_data_s;
    logic        ack_r;
    logic [31:0] dat_r;
    logic [7:0]  div_r;
    logic        csn_r;
    logic [7:0]  rx_data_r;
    logic        rx_valid_r;
    logic        overrun_r;
    logic        unused_s;

    assign unused_s = ^{wbs_dat_i[31:9], wbs_sel_i[3:2]};

    // Only a DATA write can be held off, and only while a byte is in flight.
    assign stall_s     = wbs_cyc_i & wbs_stb_i & wbs_we_i & (wbs_adr_i == ADR_DATA) & busy_s;
    assign accept_s    = wbs_cyc_i & wbs_stb_i & ~stall_s;
    assign data_wr_s   = accept_s & wbs_we_i & (wbs_adr_i == ADR_DATA);
    assign start_s     = data_wr_s & wbs_sel_i[0];
    assign ctrl_wr_s   = accept_s & wbs_we_i & (wbs_adr_i == ADR_CTRL);
    assign data_rd_s   = accept_s & ~wbs_we_i & (wbs_adr_i == ADR_DATA);
    assign status_rd_s = accept_s & ~wbs_we_i & (wbs_adr_i == ADR_STATUS);

    spi_master_shift u_shift (
        .clk     (wbs_clk_i),
        .rst     (wbs_rst_i),
        .start   (start_s),
        .tx_byte (wbs_dat_i[7:0]),
        .div     (div_r),
        .sdi     (spi_sdi),
        .busy    (busy_s),
        .done    (done_s),
        .rx_byte (rx_byte_s),
        .sck     (spi_sck),
        .sdo     (spi_sdo)
    );

    // Read-data multiplexer for the register map.
    always_comb begin
        rd_data_s = 32'd0;
        case (wbs_adr_i)
            ADR_DATA:   rd_data_s = {24'd0, rx_data_r};
            ADR_STATUS: rd_data_s = status_word(busy_s, rx_valid_r, overrun_r);
            ADR_CTRL: begin
                rd_data_s[CTRL_DIV_MSB:CTRL_DIV_LSB] = div_r;
                rd_data_s[CTRL_CS_EN]                = ~csn_r;
            end
            default:    rd_data_s = 32'd0;
        endcase
    end

    // Bus response, control register and receive flags.
    always_ff @(posedge wbs_clk_i) begin
        if (wbs_rst_i) begin
            ack_r      <= 1'b0;
            dat_r      <= 32'd0;
            div_r      <= DIV_DEFAULT;
            csn_r      <= 1'b1;
            rx_data_r  <= 8'd0;
            rx_valid_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            ack_r <= accept_s;
            dat_r <= (accept_s && !wbs_we_i) ? rd_data_s : 32'd0;
            if (ctrl_wr_s && wbs_sel_i[0]) begin
                div_r <= wbs_dat_i[CTRL_DIV_MSB:CTRL_DIV_LSB];
            end
            if (ctrl_wr_s && wbs_sel_i[1]) begin
                csn_r <= ~wbs_dat_i[CTRL_CS_EN];
            end
            if (done_s) begin
                rx_data_r <= rx_byte_s;
            end
            // Completion beats a same-cycle clearing read for both flags.
            if (done_s) begin
                rx_valid_r <= 1'b1;
            end else if (data_rd_s) begin
                rx_valid_r <= 1'b0;
            end
            if (done_s && rx_valid_r) begin
                overrun_r <= 1'b1;
            end else if (status_rd_s) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign wbs_ack_o   = ack_r;
    assign wbs_dat_o   = dat_r;
    assign wbs_stall_o = stall_s;
    assign spi_csn     = csn_r;

endmodule

// File: tb/tb_wbs_spi.sv
// Scoreboarded directed bench for wbs_spi: the driver queues the expected
// read data and ack cycle per accepted request, a monitor checks each ack.
module tb_wbs_spi;

    logic        wbs_clk_i = 1'b0;
    logic        wbs_rst_i = 1'b1;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_we_i  = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [7:0]  wbs_adr_i = 8'h00;
    logic [31:0] wbs_dat_i = 32'h0;
    logic [31:0] wbs_dat_o;
    logic        wbs_stall_o;
    logic        wbs_ack_o;
    logic        spi_sck, spi_csn, spi_sdo, spi_sdi;

    typedef struct {
        logic [31:0] data;
        int          cycle;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_n    = 0;

    logic       loop_en    = 1'b1;
    logic [7:0] slave_byte = 8'h00;
    int         fall_base  = 0;
    int         fall_cnt   = 0;
    int         rise_cnt   = 0;
    int         rise_t[0:255];
    logic       rise_b[0:255];
    logic       slv_bit;

    wbs_spi #(.DIV_DEFAULT(8'd3)) dut (
        .wbs_clk_i   (wbs_clk_i),
        .wbs_rst_i   (wbs_rst_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_dat_o   (wbs_dat_o),
        .wbs_stall_o (wbs_stall_o),
        .wbs_ack_o   (wbs_ack_o),
        .spi_sck     (spi_sck),
        .spi_csn     (spi_csn),
        .spi_sdo     (spi_sdo),
        .spi_sdi     (spi_sdi)
    );

    always #5 wbs_clk_i = ~wbs_clk_i;

    always @(posedge wbs_clk_i) cyc_n = cyc_n + 1;

    // Slave model: presents slave_byte MSB first, advancing on each SCK fall.
    always @* begin
        int idx;
        idx = fall_cnt - fall_base;
        if (idx >= 0 && idx < 8) slv_bit = slave_byte[7 - idx];
        else slv_bit = 1'b0;
    end
    assign spi_sdi = loop_en ? spi_sdo : slv_bit;

    always @(negedge spi_sck) fall_cnt = fall_cnt + 1;

    always @(posedge spi_sck) begin
        if (rise_cnt < 256) begin
            rise_t[rise_cnt] = cyc_n;
            rise_b[rise_cnt] = spi_sdo;
        end
        rise_cnt = rise_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every ack must match the head of the scoreboard.
    always @(negedge wbs_clk_i) begin
        if (wbs_ack_o) begin
            if (exp_q.size() == 0) begin
                n_checks = n_checks + 1;
                n_fail   = n_fail + 1;
                $display("FAIL unexpected_ack: got ack with dat 0x%0h, expected no ack", wbs_dat_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_data", wbs_dat_o, mon_e.data);
                check("ack_cycle", cyc_n, mon_e.cycle);
            end
        end
    end

    task automatic wb_xfer(input logic we, input logic [7:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input logic [31:0] exp, output int stalls);
        int  n;
        bit  done;
        exp_t e;
        n = 0;
        done = 1'b0;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_sel_i = sel;
        wbs_dat_i = dat;
        while (!done) begin
            @(negedge wbs_clk_i);
            if (!wbs_stall_o) begin
                e.data  = exp;
                e.cycle = cyc_n + 1;
                exp_q.push_back(e);
                done = 1'b1;
            end else begin
                n = n + 1;
                if (n > 300) begin
                    n_checks = n_checks + 1;
                    n_fail   = n_fail + 1;
                    $display("FAIL stall_timeout: got stall for %0d cycles, expected at most 300", n);
                    done = 1'b1;
                end
            end
        end
        @(posedge wbs_clk_i);
        #1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        stalls = n;
    endtask

    task automatic wr(input logic [7:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        int s;
        wb_xfer(1'b1, adr, sel, dat, 32'h0, s);
    endtask

    task automatic rd(input logic [7:0] adr, input logic [31:0] exp);
        int s;
        wb_xfer(1'b0, adr, 4'hF, 32'h0, exp, s);
    endtask

    // Busy probe: a DATA write with no byte lanes stalls while busy, then does nothing.
    task automatic busy_probe(input string name, input int exp);
        int s;
        wb_xfer(1'b1, 8'h00, 4'h0, 32'h0, 32'h0, s);
        check(name, s, exp);
    endtask

    initial begin
        int s;
        int base;
        logic [7:0] bits;

        // Reset
        repeat (2) @(posedge wbs_clk_i);
        #1;
        wbs_rst_i = 1'b0;
        @(negedge wbs_clk_i);
        check("reset_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("reset_stall", {31'd0, wbs_stall_o}, 32'd0);
        check("reset_sck", {31'd0, spi_sck}, 32'd0);
        check("reset_csn", {31'd0, spi_csn}, 32'd1);
        @(posedge wbs_clk_i);
        #1;
        rd(8'h01, 32'h0);
        rd(8'h02, 32'h003);
        rd(8'h07, 32'h0);

        // Loopback, div=0
        loop_en = 1'b1;
        wr(8'h02, 4'b0011, 32'h100);
        check("csn_after_ctrl", {31'd0, spi_csn}, 32'd0);
        base = rise_cnt;
        wr(8'h00, 4'b0001, 32'hA5);
        busy_probe("loop_busy_cycles", 16);
        check("loop_rise_count", rise_cnt - base, 8);
        for (int i = 0; i < 8; i++) bits[7 - i] = rise_b[base + i];
        check("loop_sdo_bits", {24'd0, bits}, 32'hA5);
        check("loop_sck_period", rise_t[base + 1] - rise_t[base], 2);
        rd(8'h01, 32'h2);
        rd(8'h00, 32'hA5);
        rd(8'h01, 32'h0);

        // Stall: back-to-back DATA writes, then unstalled STATUS reads
        wr(8'h00, 4'b0001, 32'h5A);
        wb_xfer(1'b1, 8'h00, 4'b0001, 32'h96, 32'h0, s);
        check("stall_second_write", s, 16);
        for (int i = 0; i < 3; i++) begin
            wb_xfer(1'b0, 8'h01, 4'hF, 32'h0, 32'h3, s);
            check("status_read_no_stall", s, 0);
        end
        busy_probe("stall_remaining_busy", 13);

        // Overrun
        rd(8'h01, 32'h6);
        rd(8'h01, 32'h2);
        rd(8'h00, 32'h96);
        rd(8'h01, 32'h0);

        // Divider with slave model; mid-transfer CTRL write affects next transfer only
        wr(8'h02, 4'b0011, 32'h103);
        loop_en    = 1'b0;
        slave_byte = 8'h3C;
        fall_base  = fall_cnt;
        base       = rise_cnt;
        wr(8'h00, 4'b0001, 32'h00);
        wb_xfer(1'b1, 8'h02, 4'b0001, 32'h100, 32'h0, s);
        check("ctrl_write_no_stall", s, 0);
        busy_probe("div3_busy_cycles", 63);
        check("div3_sck_period_first", rise_t[base + 1] - rise_t[base], 8);
        check("div3_sck_period_last", rise_t[base + 7] - rise_t[base + 6], 8);
        rd(8'h00, 32'h3C);
        rd(8'h01, 32'h0);
        rd(8'h02, 32'h100);

        // Reset during phase 7 (div=0)
        loop_en = 1'b1;
        wr(8'h00, 4'b0001, 32'hFF);
        repeat (7) @(posedge wbs_clk_i);
        #1;
        check("pre_reset_sck_high", {31'd0, spi_sck}, 32'd1);
        wbs_rst_i = 1'b1;
        @(posedge wbs_clk_i);
        #1;
        wbs_rst_i = 1'b0;
        check("midrst_sck", {31'd0, spi_sck}, 32'd0);
        check("midrst_csn", {31'd0, spi_csn}, 32'd1);
        rd(8'h01, 32'h0);
        rd(8'h02, 32'h003);

        // New transfer after reset
        wr(8'h02, 4'b0011, 32'h100);
        wr(8'h00, 4'b0001, 32'hC3);
        busy_probe("post_reset_busy", 16);
        rd(8'h01, 32'h2);
        rd(8'h00, 32'hC3);

        repeat (3) @(posedge wbs_clk_i);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected finish before 200000");
        $fatal(1);
    end

endmodule
